// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LH   = 4'd2,
        MOP_LW   = 4'd3,
        MOP_LBU  = 4'd4,
        MOP_LHU  = 4'd5,
        MOP_SB   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SW   = 4'd8
    } mem_op_t;

    // ST_ACCEPT is kept for encoding compatibility; acceptance happens in ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DRAIN  = 2'd3
    } lsu_state_t;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    function automatic logic is_mem(input logic [3:0] op);
        return (op != MOP_NONE) && (op <= MOP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

    // Index of the last byte of the access (N-1).
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: return 2'd1;
            MOP_LW, MOP_SW:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: return a[0];
            MOP_LW, MOP_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by op.
// Combinational, zero latency; no flow control.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_op_t         op,
    input  logic [31:0]     raw,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = '0;
        case (op)
            MOP_LB:  data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            MOP_LH:  data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            MOP_LW:  data[31:0] = raw;
            MOP_LBU: data[7:0] = raw[7:0];
            MOP_LHU: data[15:0] = raw[15:0];
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Byte-serial load/store unit feeding MEM; non-memory ops pass through in 1 cycle, memory ops stall the front end.
// Optional LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses are flagged on misalign_o instead of executed.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    ex_rd_data_i,
    input  logic [RADDR_W-1:0] ex_rd_addr_i,
    input  logic               ex_rd_enable_i,
    input  logic [3:0]         ex_mem_op_i,
    input  logic [XLEN-1:0]    ex_mem_addr_i,
    input  logic [XLEN-1:0]    ex_store_data_i,
    output logic               stall_o,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [XLEN-1:0]    ram_addr_o,
    output logic [7:0]         ram_wdata_o,
    input  logic [7:0]         ram_rdata_i,
    output logic               misalign_o,
    output logic [XLEN-1:0]    rd_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               rd_enable_o
);

    lsu_state_t         state;
    mem_op_t            op_q;
    logic [XLEN-1:0]    addr_q;
    logic [31:0]        sdata_q;
    logic [31:0]        acc;
    logic [31:0]        load_word;
    logic [XLEN-1:0]    load_ext;
    logic [RADDR_W-1:0] rd_addr_q;
    logic               rd_en_q;
    logic [1:0]         k;
    logic [1:0]         k_last;
    logic               store_q;
    logic               mis_now;
    logic               accept;

`ifdef LSU_ALIGN_CHECK_EN
    assign mis_now = (state == ST_IDLE) && misaligned(ex_mem_op_i, ex_mem_addr_i[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    assign accept  = (state == ST_IDLE) && is_mem(ex_mem_op_i) && !mis_now;
    assign k_last  = last_idx(op_q);
    assign store_q = is_store(op_q);

    // Stall drops in the final cycle so EX advances exactly on the completion edge.
    assign stall_o     = accept || ((state == ST_ISSUE) && !(store_q && (k == k_last)));
    assign ram_en_o    = (state == ST_ISSUE);
    assign ram_we_o    = ram_en_o ? store_q : WRITE_DISABLE;
    assign ram_addr_o  = ram_en_o ? addr_q + XLEN'(k) : '0;
    assign ram_wdata_o = ram_we_o ? sdata_q[{k, 3'b000} +: 8] : 8'h00;

    // The last byte is still on the RAM port during DRAIN; merge it without waiting.
    always_comb begin
        load_word = acc;
        load_word[{k_last, 3'b000} +: 8] = ram_rdata_i;
    end

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .op   (op_q),
        .raw  (load_word),
        .data (load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            state       <= ST_IDLE;
            op_q        <= MOP_NONE;
            addr_q      <= '0;
            sdata_q     <= '0;
            acc         <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            k           <= 2'd0;
            misalign_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_addr_o   <= '0;
            rd_enable_o <= 1'b0;
        end else begin
            misalign_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_addr_o   <= '0;
            rd_enable_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mis_now) begin
                        misalign_o <= 1'b1;
                    end else if (accept) begin
                        op_q      <= mem_op_t'(ex_mem_op_i);
                        addr_q    <= ex_mem_addr_i;
                        sdata_q   <= ex_store_data_i[31:0];
                        rd_addr_q <= ex_rd_addr_i;
                        rd_en_q   <= ex_rd_enable_i;
                        acc       <= '0;
                        k         <= 2'd0;
                        state     <= ST_ISSUE;
                    end else begin
                        rd_data_o   <= ex_rd_data_i;
                        rd_addr_o   <= ex_rd_addr_i;
                        rd_enable_o <= ex_rd_enable_i;
                    end
                end
                ST_ISSUE: begin
                    // Read data lags its strobe by one cycle, so capture byte k-1 here.
                    if (!store_q && (k != 2'd0)) begin
                        acc[{k - 2'd1, 3'b000} +: 8] <= ram_rdata_i;
                    end
                    if (k == k_last) begin
                        k     <= 2'd0;
                        state <= store_q ? ST_IDLE : ST_DRAIN;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    rd_data_o   <= load_ext;
                    rd_addr_o   <= rd_addr_q;
                    rd_enable_o <= rd_en_q;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed steps then random ops against a byte-level memory model.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        misalign;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        rd_enable;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    bit          log_we [$];
    logic [31:0] log_addr [$];
    logic [7:0]  log_wdat [$];

    lsu #(.XLEN(32), .RADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_rd_data_i    (ex_rd_data),
        .ex_rd_addr_i    (ex_rd_addr),
        .ex_rd_enable_i  (ex_rd_enable),
        .ex_mem_op_i     (ex_mem_op),
        .ex_mem_addr_i   (ex_mem_addr),
        .ex_store_data_i (ex_store_data),
        .stall_o         (stall),
        .ram_en_o        (ram_en),
        .ram_we_o        (ram_we),
        .ram_addr_o      (ram_addr),
        .ram_wdata_o     (ram_wdata),
        .ram_rdata_i     (ram_rdata),
        .misalign_o      (misalign),
        .rd_data_o       (rd_data),
        .rd_addr_o       (rd_addr),
        .rd_enable_o     (rd_enable)
    );

    always #5 clk = ~clk;

    // Never-written bytes read back as a fixed function of their address.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            log_we.push_back(ram_we);
            log_addr.push_back(ram_addr);
            log_wdat.push_back(ram_wdata);
            if (ram_we) ram[ram_addr] = ram_wdata;
            else        ram_rdata <= ram_byte(ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            MOP_LB, MOP_LBU, MOP_SB: return 1;
            MOP_LH, MOP_LHU, MOP_SH: return 2;
            MOP_LW, MOP_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    // Presents one instruction, holds it while stalled, then checks the completion.
    task automatic exec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdat,
                        input logic [31:0] alu, input logic [4:0] rda, input logic rde);
        int n, stalls, base, exp_stall;
        bit done, mis, st;
        logic [31:0] word, v, exp_data;
        logic [4:0]  exp_addr;
        logic        exp_en;
        n  = nbytes(op);
        st = (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
`ifdef LSU_ALIGN_CHECK_EN
        mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        exp_en = 1'b0; exp_data = '0; exp_addr = '0; exp_stall = 0;
        if (n == 0) begin
            exp_en = rde; exp_data = alu; exp_addr = rda;
        end else if (!mis) begin
            exp_stall = st ? n : n + 1;
            if (st) begin
                for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = sdat[8*i +: 8];
            end else begin
                word = '0;
                for (int i = 0; i < n; i++) word |= 32'(ref_byte(addr + 32'(i))) << (8*i);
                case (op)
                    MOP_LB:  begin v = word & 32'hFF;   exp_data = (v >= 32'd128)   ? v - 32'd256   : v; end
                    MOP_LH:  begin v = word & 32'hFFFF; exp_data = (v >= 32'd32768) ? v - 32'd65536 : v; end
                    MOP_LBU: exp_data = word & 32'hFF;
                    MOP_LHU: exp_data = word & 32'hFFFF;
                    default: exp_data = word;
                endcase
                exp_en = rde; exp_addr = rda;
            end
        end
        base = log_addr.size();
        ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdat;
        ex_rd_data = alu; ex_rd_addr = rda; ex_rd_enable = rde;
        stalls = 0; done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        ex_mem_op = MOP_NONE; ex_rd_enable = 1'b0;
        check("timeout", 32'(done), 32'd1);
        check("stall_cycles", stalls, exp_stall);
        check("rd_data", rd_data, exp_data);
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("rd_enable", 32'(rd_enable), 32'(exp_en));
        check("misalign", 32'(misalign), 32'(mis));
        check("strobes", log_addr.size() - base, mis ? 0 : n);
        for (int i = 0; i < n && !mis && (base + i) < log_addr.size(); i++) begin
            check("strobe_addr", log_addr[base+i], addr + 32'(i));
            check("strobe_we", 32'(log_we[base+i]), 32'(st));
            if (st) begin
                check("strobe_wdat", 32'(log_wdat[base+i]), 32'(sdat[8*i +: 8]));
                check("ram_byte", 32'(ram_byte(addr + 32'(i))), 32'(sdat[8*i +: 8]));
            end
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        ex_mem_op = MOP_NONE; ex_mem_addr = '0; ex_store_data = '0;
        ex_rd_data = '0; ex_rd_addr = '0; ex_rd_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_enable", 32'(rd_enable), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        exec(MOP_NONE, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
        exec(MOP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 5'd1, 1'b0);
        exec(MOP_SW, 32'h200, 32'h7F00_FF80, 32'h0, 5'd2, 1'b0);
        exec(MOP_LW,  32'h200, 32'h0, 32'h0, 5'd3, 1'b1);
        exec(MOP_LH,  32'h200, 32'h0, 32'h0, 5'd4, 1'b1);
        exec(MOP_LHU, 32'h200, 32'h0, 32'h0, 5'd6, 1'b1);
        exec(MOP_LB,  32'h203, 32'h0, 32'h0, 5'd7, 1'b1);
        exec(MOP_LB,  32'h200, 32'h0, 32'h0, 5'd8, 1'b1);
        exec(MOP_LBU, 32'h200, 32'h0, 32'h0, 5'd8, 1'b1);
        exec(MOP_SB,  32'h204, 32'h0000_00A5, 32'h0, 5'd0, 1'b0);
        exec(MOP_SH,  32'hFFFF_FFFF, 32'h0000_6655, 32'h0, 5'd0, 1'b0);
        exec(MOP_LW,  32'hFFFF_FFFE, 32'h0, 32'h0, 5'd10, 1'b1);
        exec(MOP_LW,  32'h101, 32'h0, 32'h0, 5'd11, 1'b1);

        // Load followed immediately by a pass-through op.
        exec(MOP_LB, 32'h200, 32'h0, 32'h0, 5'd9, 1'b1);
        base = log_addr.size();
        ex_mem_op = MOP_NONE; ex_rd_data = 32'hCAFE_0001; ex_rd_addr = 5'd12; ex_rd_enable = 1'b1;
        @(posedge clk); #1;
        ex_rd_enable = 1'b0;
        check("b2b_data", rd_data, 32'hCAFE_0001);
        check("b2b_addr", 32'(rd_addr), 32'd12);
        check("b2b_enable", 32'(rd_enable), 32'd1);
        check("b2b_no_reissue", log_addr.size() - base, 0);

        // Reset during the second ISSUE cycle of a word store.
        base = log_addr.size();
        ex_mem_op = MOP_SW; ex_mem_addr = 32'h400; ex_store_data = 32'hA1B2_C3D4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; ex_mem_op = MOP_NONE;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_strobes", log_addr.size() - base, 2);
        check("mid_rst_byte0", 32'(ram_byte(32'h400)), 32'hD4);
        check("mid_rst_byte1", 32'(ram_byte(32'h401)), 32'hC3);
        check("mid_rst_byte2", 32'(ram_byte(32'h402)), 32'(init_byte(32'h402)));
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_ram_en", 32'(ram_en), 32'd0);
        check("mid_rst_ram_we", 32'(ram_we), 32'd0);
        check("mid_rst_rd_enable", 32'(rd_enable), 32'd0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        ref_mem[32'h400] = 8'hD4;
        ref_mem[32'h401] = 8'hC3;
        exec(MOP_LW, 32'h400, 32'h0, 32'h0, 5'd13, 1'b1);

        for (int r = 0; r < 80; r++) begin
            exec(4'($urandom_range(0, 8)), 32'h300 + 32'($urandom_range(0, 15)), $urandom,
                 $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
